microwave_timer_ctrl: RTL and testbench
=======================================

Name: microwave_timer_ctrl

Overview:
Cook-timer sequencer for the microwave. It accepts BCD digits from the keypad encoder and holds the cook time as MM:SS. It counts that time down on a 1 Hz tick from the prescaler counter chain and drives the magnetron enable and the done indicator. It also enforces the door interlock and the start/pause/cancel sequencing.

Parameters:
DONE_TICKS, 3, number of tick pulses the done indicator stays high before returning to IDLE
QUICK_SECS, 8'h30, BCD seconds loaded by a quick-start from IDLE with zero time

Ports:
clk  in  1  system clock, rising edge
clear  in  1  asynchronous active-low reset
tick  in  1  one-clk-wide pulse, once per second
key_valid  in  1  one-clk strobe, key_digit valid
key_digit  in  4  BCD digit 0-9
start  in  1  one-clk start/resume pulse
stop_clr  in  1  one-clk stop/cancel pulse
door_closed  in  1  1 = door latched shut
min_tens  out  4  BCD display digit
min_ones  out  4  BCD display digit
sec_tens  out  4  BCD display digit
sec_ones  out  4  BCD display digit
mag_on  out  1  magnetron enable
done  out  1  cook-complete indicator
state  out  3  IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4

Behaviour:
- Reset (clear=0, asynchronous): state=IDLE; all digits=0; done=0; done tick count=0; mag_on=0.
- All state and digit updates are registered on the rising clk edge.
- mag_on = (state==COOK) & door_closed, combinational. The magnetron drops in the same cycle the door opens, before the state register reacts.
- Digit entry (IDLE or SET only): on key_valid with key_digit<=9, shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit. The state becomes SET.
- Digits above 9 are ignored. key_valid in COOK, PAUSE or DONE is ignored.
- Entered sec_tens may exceed 5 (e.g. 00:90 = 90 s). It counts down normally with no normalisation.
- Countdown (COOK, on tick): BCD decrement of the 4-digit value.
  - sec_ones 0 -> 9 with borrow into sec_tens.
  - sec_tens 0 -> 5 with borrow into min_ones.
  - min_ones 0 -> 9 with borrow into min_tens.
  - If the decremented value is 00:00, the state becomes DONE in the same edge.
- Transitions, evaluated by priority stop_clr > door > start > tick > key:
  - IDLE: start with door_closed and time==0 loads 00:QUICK_SECS and enters COOK.
  - IDLE: start with door_closed and time!=0 (e.g. after a cancel reset only the state) enters COOK.
  - IDLE: start with the door open is ignored.
  - SET: start with door_closed and time!=0 -> COOK. start with the door open or time==0 is ignored. stop_clr clears digits -> IDLE.
  - COOK: door_closed=0 -> PAUSE, and no decrement applies that cycle even if tick=1. stop_clr -> PAUSE with digits held.
  - PAUSE: tick is ignored. start with door_closed -> COOK. stop_clr clears digits -> IDLE.
  - DONE: done=1 and digits=00:00. Count tick pulses; on the DONE_TICKS-th tick, done=0 and state -> IDLE. stop_clr -> IDLE immediately with done=0. start is ignored.
- Simultaneous events:
  - start and key_valid in SET: start wins and the digit is dropped.
  - start and tick on entry to COOK: transition only, no decrement.
  - stop_clr and start: stop_clr wins.
- Reset mid-cook returns to IDLE with zero time; mag_on falls asynchronously.
- Only the encoded state values 0-4 are legal. Any other value recovers to IDLE on the next edge.

Test Plan:
- Reset, key 1,3,0 -> digits 01:30, state=SET. Door closed, start -> COOK, mag_on=1. 3 ticks -> 01:27. 28 more -> 00:59 (borrow).
- Key 5 then start, 5 ticks -> 00:00, state=DONE, done=1, mag_on=0. 3 ticks -> done=0, IDLE.
- Cooking at 00:10, open door in the same cycle as tick -> mag_on=0 at once, state=PAUSE, digits stay 00:10. Ticks ignored. Close door, start -> COOK at 00:10.
- IDLE zero time, start with door open -> no change. Close door, start -> 00:30, COOK. stop_clr -> PAUSE. stop_clr -> IDLE, 00:00.
- In SET, key_valid (digit 7) and start in the same cycle -> COOK with the digit dropped. key_digit=12 in SET -> ignored. key_valid during COOK -> ignored.
- Assert clear mid-COOK at 02:00 -> state=IDLE, 00:00, mag_on=0 before the next clk edge.

Source files
------------

// File: rtl/microwave_timer_ctrl.sv
// rtl/microwave_timer_ctrl.sv - microwave cook-timer sequencer: BCD MM:SS entry, 1 Hz countdown, door interlock
module microwave_timer_ctrl #(
   parameter int         DONE_TICKS = 3,
   parameter logic [7:0] QUICK_SECS = 8'h30
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       tick,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       start,
   input  logic       stop_clr,
   input  logic       door_closed,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       mag_on,
   output logic       done,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SET   = 3'd1,
      S_COOK  = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int CW = (DONE_TICKS < 2) ? 1 : $clog2(DONE_TICKS + 1);

   state_t          state_q, state_d;
   logic [15:0]     time_q, time_d;      // {min_tens, min_ones, sec_tens, sec_ones}
   logic [CW-1:0]   dcnt_q, dcnt_d;      // tick pulses seen while in DONE

   logic [15:0]     time_dec;
   logic [15:0]     time_shift;
   logic            key_ok;
   logic            time_zero;

   assign key_ok     = key_valid && (key_digit <= 4'd9);
   assign time_zero  = (time_q == 16'h0000);
   assign time_shift = {time_q[11:0], key_digit};

   // BCD decrement of MM:SS; sec_tens borrows back to 5, other digits to 9
   always_comb begin
      time_dec = time_q;
      if (time_q[3:0] != 4'd0) begin
         time_dec[3:0] = time_q[3:0] - 4'd1;
      end else begin
         time_dec[3:0] = 4'd9;
         if (time_q[7:4] != 4'd0) begin
            time_dec[7:4] = time_q[7:4] - 4'd1;
         end else begin
            time_dec[7:4] = 4'd5;
            if (time_q[11:8] != 4'd0) begin
               time_dec[11:8] = time_q[11:8] - 4'd1;
            end else begin
               time_dec[11:8]  = 4'd9;
               time_dec[15:12] = time_q[15:12] - 4'd1;
            end
         end
      end
   end

   // next state, digits and done counter; priority stop_clr > door > start > tick > key
   always_comb begin
      state_d = state_q;
      time_d  = time_q;
      dcnt_d  = '0;
      case (state_q)
         S_IDLE: begin
            if (stop_clr) begin
               state_d = S_IDLE;
            end else if (start && door_closed) begin
               state_d = S_COOK;
               if (time_zero) begin
                  time_d = {8'h00, QUICK_SECS};
               end
            end else if (key_ok) begin
               time_d  = time_shift;
               state_d = S_SET;
            end
         end
         S_SET: begin
            if (stop_clr) begin
               time_d  = 16'h0000;
               state_d = S_IDLE;
            end else if (start && door_closed && !time_zero) begin
               state_d = S_COOK;
            end else if (key_ok) begin
               time_d = time_shift;
            end
         end
         S_COOK: begin
            if (stop_clr || !door_closed) begin
               state_d = S_PAUSE;
            end else if (tick) begin
               time_d = time_dec;
               if (time_dec == 16'h0000) begin
                  state_d = S_DONE;
               end
            end
         end
         S_PAUSE: begin
            if (stop_clr) begin
               time_d  = 16'h0000;
               state_d = S_IDLE;
            end else if (start && door_closed) begin
               state_d = S_COOK;
            end
         end
         S_DONE: begin
            dcnt_d = dcnt_q;
            if (stop_clr) begin
               dcnt_d  = '0;
               state_d = S_IDLE;
            end else if (tick) begin
               if (dcnt_q == CW'(DONE_TICKS - 1)) begin
                  dcnt_d  = '0;
                  state_d = S_IDLE;
               end else begin
                  dcnt_d = dcnt_q + CW'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // state, digit and done-count registers
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q <= S_IDLE;
         time_q  <= 16'h0000;
         dcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         time_q  <= time_d;
         dcnt_q  <= dcnt_d;
      end
   end

   assign min_tens = time_q[15:12];
   assign min_ones = time_q[11:8];
   assign sec_tens = time_q[7:4];
   assign sec_ones = time_q[3:0];
   // door opening kills the magnetron combinationally, ahead of the state register
   assign mag_on   = (state_q == S_COOK) && door_closed;
   assign done     = (state_q == S_DONE);
   assign state    = state_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// tb/tb_microwave_timer_ctrl.sv - table-driven bench for microwave_timer_ctrl
module tb_microwave_timer_ctrl;

   localparam logic [2:0] IDLE = 3'd0, SET = 3'd1, COOK = 3'd2, PAUSE = 3'd3, DONE = 3'd4;

   logic       clk = 1'b0;
   logic       clear = 1'b0;
   logic       tick = 1'b0, key_valid = 1'b0, start = 1'b0, stop_clr = 1'b0, door_closed = 1'b1;
   logic [3:0] key_digit = 4'd0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       mag_on, done;
   logic [2:0] state;

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      logic        tk;
      logic        kv;
      logic [3:0]  kd;
      logic        st;
      logic        sp;
      logic        dr;
      int          n;
      logic [15:0] e_dig;
      logic [2:0]  e_state;
      logic        e_mag;
      logic        e_done;
   } vec_t;

   vec_t tbl[$];

   microwave_timer_ctrl #(.DONE_TICKS(3), .QUICK_SECS(8'h30)) dut (
      .clk(clk), .clear(clear), .tick(tick), .key_valid(key_valid), .key_digit(key_digit),
      .start(start), .stop_clr(stop_clr), .door_closed(door_closed),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
      .mag_on(mag_on), .done(done), .state(state)
   );

   always #5 clk = ~clk;

   task automatic add(input logic tk, input logic kv, input logic [3:0] kd, input logic st,
                      input logic sp, input logic dr, input int n, input logic [15:0] dig,
                      input logic [2:0] s, input logic m, input logic d);
      vec_t v;
      v.tk = tk; v.kv = kv; v.kd = kd; v.st = st; v.sp = sp; v.dr = dr; v.n = n;
      v.e_dig = dig; v.e_state = s; v.e_mag = m; v.e_done = d;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [15:0] dig, input logic [2:0] s,
                        input logic m, input logic d);
      logic [15:0] act;
      act = {min_tens, min_ones, sec_tens, sec_ones};
      nvec++;
      if (act !== dig || state !== s || mag_on !== m || done !== d) begin
         nerr++;
         $display("FAIL %s: got dig=%h state=%0d mag=%b done=%b, want dig=%h state=%0d mag=%b done=%b",
                  name, act, state, mag_on, done, dig, s, m, d);
      end
   endtask

   initial begin
      //  tk kv kd  st sp dr  n   digits    state  mag done
      add(0, 1, 1,  0, 0, 1, 1, 16'h0001, SET,   0, 0);
      add(0, 1, 3,  0, 0, 1, 1, 16'h0013, SET,   0, 0);
      add(0, 1, 0,  0, 0, 1, 1, 16'h0130, SET,   0, 0);
      add(0, 0, 0,  1, 0, 1, 1, 16'h0130, COOK,  1, 0);
      add(1, 0, 0,  0, 0, 1, 1, 16'h0129, COOK,  1, 0);
      add(1, 0, 0,  0, 0, 1, 1, 16'h0128, COOK,  1, 0);
      add(1, 0, 0,  0, 0, 1, 1, 16'h0127, COOK,  1, 0);
      add(1, 0, 0,  0, 0, 1, 28, 16'h0059, COOK, 1, 0);
      add(0, 0, 0,  0, 1, 1, 1, 16'h0059, PAUSE, 0, 0);
      add(0, 0, 0,  0, 1, 1, 1, 16'h0000, IDLE,  0, 0);
      add(0, 1, 5,  0, 0, 1, 1, 16'h0005, SET,   0, 0);
      add(0, 0, 0,  1, 0, 1, 1, 16'h0005, COOK,  1, 0);
      add(1, 0, 0,  0, 0, 1, 4, 16'h0001, COOK,  1, 0);
      add(1, 0, 0,  0, 0, 1, 1, 16'h0000, DONE,  0, 1);
      add(1, 0, 0,  0, 0, 1, 2, 16'h0000, DONE,  0, 1);
      add(1, 0, 0,  0, 0, 1, 1, 16'h0000, IDLE,  0, 0);
      add(0, 1, 1,  0, 0, 1, 1, 16'h0001, SET,   0, 0);
      add(0, 1, 0,  0, 0, 1, 1, 16'h0010, SET,   0, 0);
      add(0, 0, 0,  1, 0, 1, 1, 16'h0010, COOK,  1, 0);
      add(1, 0, 0,  0, 0, 0, 1, 16'h0010, PAUSE, 0, 0);
      add(1, 0, 0,  0, 0, 0, 3, 16'h0010, PAUSE, 0, 0);
      add(0, 0, 0,  0, 0, 1, 1, 16'h0010, PAUSE, 0, 0);
      add(1, 0, 0,  0, 0, 1, 1, 16'h0010, PAUSE, 0, 0);
      add(0, 0, 0,  1, 0, 1, 1, 16'h0010, COOK,  1, 0);
      add(1, 0, 0,  0, 0, 1, 1, 16'h0009, COOK,  1, 0);
      add(0, 0, 0,  0, 1, 1, 1, 16'h0009, PAUSE, 0, 0);
      add(0, 0, 0,  0, 1, 1, 1, 16'h0000, IDLE,  0, 0);
      add(0, 0, 0,  1, 0, 0, 1, 16'h0000, IDLE,  0, 0);
      add(0, 0, 0,  1, 0, 1, 1, 16'h0030, COOK,  1, 0);
      add(0, 0, 0,  0, 1, 1, 1, 16'h0030, PAUSE, 0, 0);
      add(0, 0, 0,  0, 1, 1, 1, 16'h0000, IDLE,  0, 0);
      add(0, 1, 2,  0, 0, 1, 1, 16'h0002, SET,   0, 0);
      add(0, 1, 12, 0, 0, 1, 1, 16'h0002, SET,   0, 0);
      add(0, 1, 7,  1, 0, 1, 1, 16'h0002, COOK,  1, 0);
      add(0, 1, 4,  0, 0, 1, 1, 16'h0002, COOK,  1, 0);
      add(1, 0, 0,  0, 0, 1, 1, 16'h0001, COOK,  1, 0);
      add(0, 0, 0,  0, 1, 1, 1, 16'h0001, PAUSE, 0, 0);
      add(1, 0, 0,  1, 0, 1, 1, 16'h0001, COOK,  1, 0);
      add(0, 0, 0,  1, 1, 1, 1, 16'h0001, PAUSE, 0, 0);
      add(0, 0, 0,  1, 1, 1, 1, 16'h0000, IDLE,  0, 0);
      add(0, 1, 9,  0, 0, 1, 1, 16'h0009, SET,   0, 0);
      add(0, 1, 0,  0, 0, 1, 1, 16'h0090, SET,   0, 0);
      add(0, 0, 0,  1, 0, 1, 1, 16'h0090, COOK,  1, 0);
      add(1, 0, 0,  0, 0, 1, 1, 16'h0089, COOK,  1, 0);
      add(0, 0, 0,  0, 1, 1, 1, 16'h0089, PAUSE, 0, 0);
      add(0, 0, 0,  0, 1, 1, 1, 16'h0000, IDLE,  0, 0);
      add(0, 1, 1,  0, 0, 1, 1, 16'h0001, SET,   0, 0);
      add(0, 1, 0,  0, 0, 1, 1, 16'h0010, SET,   0, 0);
      add(0, 1, 0,  0, 0, 1, 1, 16'h0100, SET,   0, 0);
      add(0, 1, 0,  0, 0, 1, 1, 16'h1000, SET,   0, 0);
      add(0, 0, 0,  1, 0, 1, 1, 16'h1000, COOK,  1, 0);
      add(1, 0, 0,  0, 0, 1, 1, 16'h0959, COOK,  1, 0);
      add(0, 0, 0,  0, 1, 1, 1, 16'h0959, PAUSE, 0, 0);
      add(0, 0, 0,  0, 1, 1, 1, 16'h0000, IDLE,  0, 0);
      add(0, 1, 1,  0, 0, 1, 1, 16'h0001, SET,   0, 0);
      add(0, 0, 0,  1, 0, 1, 1, 16'h0001, COOK,  1, 0);
      add(1, 0, 0,  0, 0, 1, 1, 16'h0000, DONE,  0, 1);
      add(0, 0, 0,  0, 1, 1, 1, 16'h0000, IDLE,  0, 0);
      add(0, 1, 2,  0, 0, 1, 1, 16'h0002, SET,   0, 0);
      add(0, 1, 0,  0, 0, 1, 1, 16'h0020, SET,   0, 0);
      add(0, 1, 0,  0, 0, 1, 1, 16'h0200, SET,   0, 0);
      add(0, 0, 0,  1, 0, 1, 1, 16'h0200, COOK,  1, 0);

      repeat (2) @(posedge clk);
      #1;
      check("reset", 16'h0000, IDLE, 0, 0);
      clear = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset", 16'h0000, IDLE, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         for (int r = 0; r < tbl[i].n; r++) begin
            tick = tbl[i].tk; key_valid = tbl[i].kv; key_digit = tbl[i].kd;
            start = tbl[i].st; stop_clr = tbl[i].sp; door_closed = tbl[i].dr;
            @(posedge clk);
            #1;
         end
         check($sformatf("vec%0d", i), tbl[i].e_dig, tbl[i].e_state, tbl[i].e_mag, tbl[i].e_done);
      end
      tick = 0; key_valid = 0; key_digit = 0; start = 0; stop_clr = 0; door_closed = 1;

      // door opens together with a tick: magnetron drops before the edge, no decrement after it
      tick = 1; door_closed = 0;
      #1;
      check("door_open_comb", 16'h0200, COOK, 0, 0);
      @(posedge clk);
      #1;
      check("door_open_pause", 16'h0200, PAUSE, 0, 0);
      tick = 0; door_closed = 1; start = 1;
      @(posedge clk);
      #1;
      start = 0;
      check("resume", 16'h0200, COOK, 1, 0);

      // asynchronous reset mid-cook, observed before any clock edge
      #2;
      clear = 1'b0;
      #1;
      check("async_clear", 16'h0000, IDLE, 0, 0);
      #1;
      clear = 1'b1;
      @(posedge clk);
      #1;
      check("after_clear", 16'h0000, IDLE, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
